// File: rtl/guard_pkg.sv
// guard_pkg: shared types and constants for the guard sprite sequencer.
//   guard_state_t : walk/pause FSM states
//   guard_regs_t  : registered FSM state, position and counters
//   FRAME_W/H     : sprite dimensions in pixels
//   RIGHT1..LEFT2 : frame_sel encodings ({facing_left, step})
package guard_pkg;

    localparam int FRAME_W = 21;
    localparam int FRAME_H = 45;
    localparam int CNT_W   = 8;

    localparam logic [1:0] RIGHT1 = 2'd0;
    localparam logic [1:0] RIGHT2 = 2'd1;
    localparam logic [1:0] LEFT1  = 2'd2;
    localparam logic [1:0] LEFT2  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WALK_R,
        PAUSE_R,
        WALK_L,
        PAUSE_L
    } guard_state_t;

    typedef struct packed {
        guard_state_t     state;
        logic [9:0]       x;
        logic             facing;
        logic             step;
        logic [CNT_W-1:0] hold;
        logic [CNT_W-1:0] pause;
    } guard_regs_t;

endpackage

// File: rtl/guard_pixel_addr.sv
// guard_pixel_addr: per-pixel hit test and frame ROM address generation.
//   vga_clk, reset_n     : pixel clock, async active-low reset
//   DrawX, DrawY, blank  : raster position and visible-area flag
//   guard_x              : sprite left x (stable over the visible frame)
//   rom_address          : ly*FRAME_W+lx, registered one cycle after DrawX/DrawY
//   sprite_on            : hit delayed two cycles to line up with ROM q
module guard_pixel_addr
    import guard_pkg::*;
#(
    parameter int GUARD_Y = 300
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic [9:0]  guard_x,
    output logic [10:0] rom_address,
    output logic        sprite_on
);

    logic [10:0] lx, ly, addr;
    logic        hit;
    logic [1:0]  vld_pipe;

    // 11-bit differences; bit 10 set means the pixel is left of / above the sprite
    always_comb begin
        lx   = {1'b0, DrawX} - {1'b0, guard_x};
        ly   = {1'b0, DrawY} - 11'(GUARD_Y);
        hit  = blank & ~lx[10] & (lx < 11'(FRAME_W)) & ~ly[10] & (ly < 11'(FRAME_H));
        addr = ly * 11'(FRAME_W) + lx;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            vld_pipe    <= '0;
        end else begin
            rom_address <= hit ? addr : 11'd0;
            vld_pipe    <= {vld_pipe[0], hit};
        end
    end

    assign sprite_on = vld_pipe[1];

endmodule

// File: rtl/guard_sprite_sequencer.sv
// guard_sprite_sequencer: walks the guard between X_MIN and X_MAX, pausing at
// each limit, and animates the walk cycle. All updates happen on frame_start
// so position and frame are stable for the whole visible frame.
//   vga_clk, reset_n        : pixel clock, async active-low reset
//   frame_start             : one-cycle pulse at start of vertical blanking
//   enable                  : walking permitted
//   DrawX, DrawY, blank     : raster position, visible-area flag
//   guard_x, facing_left    : current sprite position and facing
//   frame_sel               : {facing_left, step} frame ROM select
//   rom_address, sprite_on  : pixel-path outputs from guard_pixel_addr
module guard_sprite_sequencer
    import guard_pkg::*;
#(
    parameter int GUARD_Y      = 300,
    parameter int X_MIN        = 40,
    parameter int X_MAX        = 560,
    parameter int STEP         = 2,
    parameter int FRAME_HOLD   = 8,
    parameter int PAUSE_FRAMES = 30
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        enable,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    output logic [9:0]  guard_x,
    output logic        facing_left,
    output logic [1:0]  frame_sel,
    output logic [10:0] rom_address,
    output logic        sprite_on
);

    guard_regs_t cur, nxt;
    logic [10:0] x_inc;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            cur.state  <= IDLE;
            cur.x      <= 10'(X_MIN);
            cur.facing <= 1'b0;
            cur.step   <= 1'b0;
            cur.hold   <= '0;
            cur.pause  <= '0;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt   = cur;
        x_inc = {1'b0, cur.x} + 11'(STEP);
        if (frame_start) begin
            if (!enable) begin
                // Stop in place: keep x and facing, drop animation state
                if (cur.state != IDLE) begin
                    nxt.state = IDLE;
                    nxt.step  = 1'b0;
                    nxt.hold  = '0;
                    nxt.pause = '0;
                end
            end else begin
                unique case (cur.state)
                    IDLE: begin
                        nxt.state = cur.facing ? WALK_L : WALK_R;
                        nxt.step  = 1'b0;
                        nxt.hold  = '0;
                        nxt.pause = '0;
                    end
                    WALK_R, WALK_L: begin
                        // Compare before moving so an uneven span clamps, never overshoots
                        if ((cur.state == WALK_R) ? (x_inc >= 11'(X_MAX))
                                                  : ({1'b0, cur.x} <= 11'(X_MIN + STEP))) begin
                            nxt.x     = (cur.state == WALK_R) ? 10'(X_MAX) : 10'(X_MIN);
                            nxt.state = (cur.state == WALK_R) ? PAUSE_R : PAUSE_L;
                            nxt.step  = 1'b0;
                            nxt.hold  = '0;
                            nxt.pause = '0;
                        end else begin
                            nxt.x = (cur.state == WALK_R) ? x_inc[9:0] : cur.x - 10'(STEP);
                            if (cur.hold == CNT_W'(FRAME_HOLD - 1)) begin
                                nxt.hold = '0;
                                nxt.step = ~cur.step;
                            end else begin
                                nxt.hold = cur.hold + 1'b1;
                            end
                        end
                    end
                    PAUSE_R, PAUSE_L: begin
                        nxt.step = 1'b0;
                        if (cur.pause == CNT_W'(PAUSE_FRAMES - 1)) begin
                            nxt.facing = ~cur.facing;
                            nxt.state  = (cur.state == PAUSE_R) ? WALK_L : WALK_R;
                            nxt.pause  = '0;
                            nxt.hold   = '0;
                        end else begin
                            nxt.pause = cur.pause + 1'b1;
                        end
                    end
                    default: nxt.state = IDLE;
                endcase
            end
        end
    end

    assign guard_x     = cur.x;
    assign facing_left = cur.facing;
    assign frame_sel   = {cur.facing, cur.step};

    guard_pixel_addr #(
        .GUARD_Y (GUARD_Y)
    ) u_pix (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .guard_x     (cur.x),
        .rom_address (rom_address),
        .sprite_on   (sprite_on)
    );

endmodule
